int_ctrl: RTL and testbench

- Interrupt controller feeding the multicycle CPU control FSM: INT to the FSM, cause code to CP0.
- Synchronises asynchronous peripheral interrupt lines, latches rising edges as pending, applies a mask and the global enable, and selects a source by fixed priority.
- Raises INT and holds it until the control FSM acknowledges entry to the interrupt sequence (write EPC). Blocks further requests until the handler returns (eret).
- Sits between the peripherals and the control FSM / CP0 write path.

---
 rtl/int_pkg.sv | 29 ++
 rtl/irq_sync_edge.sv | 28 ++
 rtl/int_ctrl.sv | 109 ++++++++++
 tb/tb_int_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and helpers for the interrupt controller: FSM encoding,
// default sizing and a lowest-index-wins priority encoder.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

    localparam int N_SRC_DEF   = 8;
    localparam int CAUSE_W_DEF = 3;
    // Encoder input width; callers zero-extend their eligible vector to this.
    localparam int MAX_SRC     = 32;

    function automatic logic prio_enc(input logic [MAX_SRC-1:0] vec, output int idx);
        logic valid;
        valid = 1'b0;
        idx   = 0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = i;
            end
        end
        return valid;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per interrupt line plus a delay flop; emits a
// one-cycle pulse on each synchronised rising edge.
module irq_sync_edge #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] i_irq,
    output logic [N_SRC-1:0] o_rise
);

    logic [N_SRC-1:0] r_s1, r_s2, r_s2d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_s2d <= '0;
        end else begin
            r_s1  <= i_irq;
            r_s2  <= r_s1;
            r_s2d <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s2d;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, fixed priority and
// a REQ/SERVICE handshake with the CPU control FSM (int_ack, eret).
module int_ctrl
    import int_pkg::*;
#(
    parameter int N_SRC   = N_SRC_DEF,
    parameter int CAUSE_W = CAUSE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic               ie,
    input  logic               mask_we,
    input  logic [N_SRC-1:0]   mask_wdata,
    input  logic               int_ack,
    input  logic               eret,
    output logic               INT,
    output logic [CAUSE_W-1:0] Cause,
    output logic [N_SRC-1:0]   pending_out,
    output logic [N_SRC-1:0]   mask_out,
    output logic [N_SRC-1:0]   inservice_out
);

    state_t             r_state, w_state_nxt;
    logic               r_int, w_int_nxt;
    logic [CAUSE_W-1:0] r_cause, w_cause_nxt;
    logic [N_SRC-1:0]   r_pend, w_pend_nxt;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_insvc, w_insvc_nxt;
    logic [N_SRC-1:0]   w_rise, w_elig, w_cause_oh;
    logic               w_win_vld;
    int                 w_win_idx;

    irq_sync_edge #(.N_SRC(N_SRC)) u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .i_irq  (irq_src),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_int   <= 1'b0;
            r_cause <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_insvc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_int   <= w_int_nxt;
            r_cause <= w_cause_nxt;
            r_pend  <= w_pend_nxt;
            r_insvc <= w_insvc_nxt;
            if (mask_we)
                r_mask <= mask_wdata;
        end
    end

    always_comb begin
        w_elig      = r_pend & r_mask;
        w_win_vld   = prio_enc(MAX_SRC'(w_elig), w_win_idx);
        w_cause_oh  = '0;
        w_cause_oh[r_cause] = 1'b1;
        w_state_nxt = r_state;
        w_int_nxt   = r_int;
        w_cause_nxt = r_cause;
        // A fresh edge is OR-ed in after any clear, so set beats clear.
        w_pend_nxt  = r_pend | w_rise;
        w_insvc_nxt = r_insvc;
        case (r_state)
            IDLE: begin
                if (ie && w_win_vld) begin
                    w_int_nxt   = 1'b1;
                    w_cause_nxt = CAUSE_W'(w_win_idx);
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_int_nxt   = 1'b0;
                    w_pend_nxt  = (r_pend & ~w_cause_oh) | w_rise;
                    w_insvc_nxt = r_insvc | w_cause_oh;
                    w_state_nxt = SERVICE;
                end else if (!ie || !w_elig[r_cause]) begin
                    w_int_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    w_insvc_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_int_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign INT           = r_int;
    assign Cause         = r_cause;
    assign pending_out   = r_pend;
    assign mask_out      = r_mask;
    assign inservice_out = r_insvc;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with fixed expectations, then a
// randomized run compared every cycle against a behavioural model.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq_src = '0;
    logic       ie = 1'b0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = '0;
    logic       int_ack = 1'b0;
    logic       eret = 1'b0;
    logic       INT;
    logic [2:0] Cause;
    logic [7:0] pending_out, mask_out, inservice_out;

    int checks = 0;
    int errors = 0;

    int_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .irq_src       (irq_src),
        .ie            (ie),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .int_ack       (int_ack),
        .eret          (eret),
        .INT           (INT),
        .Cause         (Cause),
        .pending_out   (pending_out),
        .mask_out      (mask_out),
        .inservice_out (inservice_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: m_mode 0 idle, 1 requesting, 2 in service.
    // hist1..hist3 hold irq_src as seen at the previous three edges.
    int       m_mode;
    bit       m_int;
    bit [2:0] m_cause;
    bit [7:0] m_pend, m_mask, m_insvc;
    bit [7:0] hist1, hist2, hist3;
    bit [7:0] m_new, m_elig;
    int       m_win;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_int = 0; m_cause = 0;
            m_pend = 0; m_mask = 0; m_insvc = 0;
            hist1 = 0; hist2 = 0; hist3 = 0;
        end else begin
            m_new  = hist2 & ~hist3;
            m_elig = m_pend & m_mask;
            m_win  = -1;
            for (int i = 7; i >= 0; i--)
                if (m_elig[i]) m_win = i;
            if (m_mode == 0) begin
                if (ie && m_win >= 0) begin
                    m_int = 1; m_cause = 3'(m_win); m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (int_ack) begin
                    m_int = 0; m_pend[m_cause] = 0; m_insvc[m_cause] = 1; m_mode = 2;
                end else if (!ie || !m_elig[m_cause]) begin
                    m_int = 0; m_mode = 0;
                end
            end else if (eret) begin
                m_insvc = 0; m_mode = 0;
            end
            m_pend = m_pend | m_new;
            if (mask_we) m_mask = mask_wdata;
            hist3 = hist2; hist2 = hist1; hist1 = irq_src;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int got %0h exp 0", INT); end
        checks++; if (Cause !== 3'd0) begin errors++; $display("FAIL reset_cause got %0h exp 0", Cause); end
        checks++; if (pending_out !== 8'h00) begin errors++; $display("FAIL reset_pend got %0h exp 0", pending_out); end
        checks++; if (mask_out !== 8'h00) begin errors++; $display("FAIL reset_mask got %0h exp 0", mask_out); end
        checks++; if (inservice_out !== 8'h00) begin errors++; $display("FAIL reset_insvc got %0h exp 0", inservice_out); end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        mask_we = 1; mask_wdata = 8'hFF; ie = 1;
        step();
        mask_we = 0;
        checks++; if (mask_out !== 8'hFF) begin errors++; $display("FAIL basic_mask got %0h exp ff", mask_out); end
        irq_src = 8'h08;
        step(2);
        checks++; if (pending_out !== 8'h00) begin errors++; $display("FAIL basic_pend_early got %0h exp 0", pending_out); end
        step();
        checks++; if (pending_out !== 8'h08) begin errors++; $display("FAIL basic_pend got %0h exp 08", pending_out); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL basic_int_early got %0h exp 0", INT); end
        step();
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL basic_int got %0h exp 1", INT); end
        checks++; if (Cause !== 3'd3) begin errors++; $display("FAIL basic_cause got %0h exp 3", Cause); end
        step(2);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL basic_int_hold got %0h exp 1", INT); end
        int_ack = 1; irq_src = 8'h00;
        step();
        int_ack = 0;
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL basic_ack_int got %0h exp 0", INT); end
        checks++; if (pending_out !== 8'h00) begin errors++; $display("FAIL basic_ack_pend got %0h exp 0", pending_out); end
        checks++; if (inservice_out !== 8'h08) begin errors++; $display("FAIL basic_ack_insvc got %0h exp 08", inservice_out); end
        eret = 1;
        step();
        eret = 0;
        checks++; if (inservice_out !== 8'h00) begin errors++; $display("FAIL basic_eret_insvc got %0h exp 0", inservice_out); end
        step();
    endtask

    task automatic test_priority;
        irq_src = 8'h24;
        step(3);
        checks++; if (pending_out !== 8'h24) begin errors++; $display("FAIL prio_pend got %0h exp 24", pending_out); end
        step();
        checks++; if (Cause !== 3'd2 || INT !== 1'b1) begin errors++; $display("FAIL prio_cause got %0h/%0h exp 2/1", Cause, INT); end
        irq_src = 8'h00; int_ack = 1;
        step();
        int_ack = 0;
        checks++; if (pending_out !== 8'h20) begin errors++; $display("FAIL prio_pend_ack got %0h exp 20", pending_out); end
        step();
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL prio_nonest got %0h exp 0", INT); end
        eret = 1;
        step();
        eret = 0;
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL prio_eret_int got %0h exp 0", INT); end
        step();
        checks++; if (INT !== 1'b1 || Cause !== 3'd5) begin errors++; $display("FAIL prio_next got %0h/%0h exp 1/5", INT, Cause); end
        int_ack = 1; step(); int_ack = 0;
        eret = 1; step(); eret = 0;
        step();
    endtask

    task automatic test_mask;
        mask_we = 1; mask_wdata = 8'h00; step(); mask_we = 0;
        irq_src = 8'h02;
        step(4);
        checks++; if (pending_out !== 8'h02) begin errors++; $display("FAIL mask_pend got %0h exp 02", pending_out); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mask_blocked got %0h exp 0", INT); end
        mask_we = 1; mask_wdata = 8'h02;
        step();
        mask_we = 0;
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mask_load_int got %0h exp 0", INT); end
        step();
        checks++; if (INT !== 1'b1 || Cause !== 3'd1) begin errors++; $display("FAIL mask_int got %0h/%0h exp 1/1", INT, Cause); end
        irq_src = 8'h00;
        int_ack = 1; step(); int_ack = 0;
        eret = 1; step(); eret = 0;
        mask_we = 1; mask_wdata = 8'hFF; step(); mask_we = 0;
    endtask

    task automatic test_ie_and_service;
        irq_src = 8'h10;
        step(4);
        checks++; if (INT !== 1'b1 || Cause !== 3'd4) begin errors++; $display("FAIL ie_req got %0h/%0h exp 1/4", INT, Cause); end
        ie = 0;
        step();
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL ie_drop got %0h exp 0", INT); end
        checks++; if (pending_out !== 8'h10) begin errors++; $display("FAIL ie_keep_pend got %0h exp 10", pending_out); end
        ie = 1;
        step();
        checks++; if (INT !== 1'b1 || Cause !== 3'd4) begin errors++; $display("FAIL ie_restore got %0h/%0h exp 1/4", INT, Cause); end
        int_ack = 1; irq_src = 8'h01;
        step();
        int_ack = 0;
        step(2);
        checks++; if (pending_out !== 8'h01) begin errors++; $display("FAIL svc_pend got %0h exp 01", pending_out); end
        step();
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL svc_nonest got %0h exp 0", INT); end
        eret = 1; step(); eret = 0;
        step();
        checks++; if (INT !== 1'b1 || Cause !== 3'd0) begin errors++; $display("FAIL svc_after got %0h/%0h exp 1/0", INT, Cause); end
    endtask

    task automatic test_async_reset;
        // Still in REQ with Cause 0 from the previous scenario.
        #2 reset = 1'b0;
        #1;
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL areset_int got %0h exp 0", INT); end
        checks++; if (Cause !== 3'd0) begin errors++; $display("FAIL areset_cause got %0h exp 0", Cause); end
        checks++; if (pending_out !== 8'h00) begin errors++; $display("FAIL areset_pend got %0h exp 0", pending_out); end
        checks++; if (mask_out !== 8'h00) begin errors++; $display("FAIL areset_mask got %0h exp 0", mask_out); end
        checks++; if (inservice_out !== 8'h00) begin errors++; $display("FAIL areset_insvc got %0h exp 0", inservice_out); end
        irq_src = 8'h00;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random;
        int bad;
        bad = 0;
        ie = 1; mask_we = 1; mask_wdata = 8'hFF;
        step();
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (INT !== m_int || Cause !== m_cause || pending_out !== m_pend ||
                mask_out !== m_mask || inservice_out !== m_insvc) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_cyc%0d got int=%0h cause=%0h pend=%0h mask=%0h insvc=%0h exp int=%0h cause=%0h pend=%0h mask=%0h insvc=%0h",
                             c, INT, Cause, pending_out, mask_out, inservice_out,
                             m_int, m_cause, m_pend, m_mask, m_insvc);
                bad++;
            end
            if ($urandom_range(2) == 0)
                irq_src[$urandom_range(7)] = ~irq_src[$urandom_range(7)];
            ie         = ($urandom_range(15) != 0);
            mask_we    = ($urandom_range(29) == 0);
            mask_wdata = 8'($urandom);
            int_ack    = (m_int && $urandom_range(2) == 0) || ($urandom_range(19) == 0);
            eret       = (m_mode == 2 && $urandom_range(3) == 0) || ($urandom_range(24) == 0);
            step();
        end
        irq_src = 0; ie = 0; mask_we = 0; int_ack = 0; eret = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_ie_and_service();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
